// File: rtl/sc_lfsr_checker.sv
// sc_lfsr_checker
// Receives one 8-bit word per valid cycle and checks it against the Fibonacci
// sequence next(x) = {x[6:0], x[7]^x[4]}. A HUNT/VERIFY/LOCKED state machine
// acquires the sequence and then counts mismatched words in a saturating
// error counter with a synchronous clear.
//
// Build option:
//   SC_LFSR_CHECKER_LOSSDET_EN  when defined, LOSS_COUNT consecutive mismatches
//                               while LOCKED drop back to HUNT. When undefined,
//                               LOCKED is left only by reset.
module sc_lfsr_checker #(
  parameter int LOCK_COUNT   = 4,  // consecutive matches needed to declare lock
  parameter int LOSS_COUNT   = 3,  // consecutive mismatches that drop lock
  parameter int ERRCNT_WIDTH = 8   // width of the error counter
) (
  input  logic                    SC_RegSHIFTER_CLOCK_50,
  input  logic                    SC_RegSHIFTER_RESET_InHigh,
  input  logic [7:0]              SC_LFSRCHK_data_InBUS,
  input  logic                    SC_LFSRCHK_valid_In,
  input  logic                    SC_LFSRCHK_clear_In,
  output logic                    SC_LFSRCHK_locked_Out,
  output logic                    SC_LFSRCHK_error_Out,
  output logic [ERRCNT_WIDTH-1:0] SC_LFSRCHK_errcnt_OutBUS,
  output logic [7:0]              SC_LFSRCHK_expected_OutBUS
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Successor of the 8-bit Fibonacci LFSR.
  function automatic logic [7:0] f_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[4]};
  endfunction

  state_t                  r_state;
  logic [MATCH_W-1:0]      r_match_cnt;
  logic [7:0]              r_pred;
  logic                    r_locked;
  logic                    r_error;
  logic [ERRCNT_WIDTH-1:0] r_errcnt;

  logic       w_match;
  logic [7:0] w_next_data;
  logic [7:0] w_next_pred;
  logic       w_lock_mismatch;
  logic       w_errcnt_full;
  logic       w_lock_done;
  logic       w_loss;

  assign w_match         = (SC_LFSRCHK_data_InBUS == r_pred);
  assign w_next_data     = f_next(SC_LFSRCHK_data_InBUS);
  assign w_next_pred     = f_next(r_pred);
  assign w_lock_mismatch = SC_LFSRCHK_valid_In && (r_state == LOCKED) && !w_match;
  assign w_errcnt_full   = &r_errcnt;
  // The LOCK_COUNT-th match is the one arriving while LOCK_COUNT-1 are banked.
  assign w_lock_done     = (r_match_cnt == MATCH_W'(LOCK_COUNT - 1));

`ifdef SC_LFSR_CHECKER_LOSSDET_EN
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);

  logic [MISS_W-1:0] r_miss_cnt;

  // A mismatch that completes a run of LOSS_COUNT consecutive misses drops lock.
  assign w_loss = w_lock_mismatch && (r_miss_cnt == MISS_W'(LOSS_COUNT - 1));

  // Consecutive-mismatch counter; only moves on valid words while LOCKED.
  always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
    if (SC_RegSHIFTER_RESET_InHigh) begin
      r_miss_cnt <= '0;
    end else if (SC_LFSRCHK_valid_In && (r_state == LOCKED)) begin
      if (w_match || w_loss) begin
        r_miss_cnt <= '0;
      end else begin
        r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end
`else
  // Loss detection is compiled out: lock is held until reset.
  localparam int unused_loss_count = LOSS_COUNT;

  assign w_loss = 1'b0;
`endif

  // Acquisition/tracking state machine with registered lock flag and predictor.
  // NOTE: every flop here is written with <= so all registers update from the
  // same pre-edge values; a blocking = would let later statements see new state.
  always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
    // NOTE: the reset branch lists every register of this block, so the
    // asynchronous reset pulls all outputs to their idle values without a clock.
    if (SC_RegSHIFTER_RESET_InHigh) begin
      r_state     <= HUNT;
      r_pred      <= 8'h01;
      r_match_cnt <= '0;
      r_locked    <= 1'b0;
    end else if (SC_LFSRCHK_valid_In) begin
      case (r_state)
        HUNT: begin
          // 0x00 is the LFSR lockup value and can never seed a valid sequence.
          if (SC_LFSRCHK_data_InBUS != 8'h00) begin
            r_pred      <= w_next_data;
            r_match_cnt <= '0;
            r_state     <= VERIFY;
          end
        end
        VERIFY: begin
          // Re-seed from the received word whether or not it matched.
          r_pred <= w_next_data;
          if (w_match) begin
            if (w_lock_done) begin
              r_match_cnt <= '0;
              r_state     <= LOCKED;
              r_locked    <= 1'b1;
            end else begin
              r_match_cnt <= r_match_cnt + 1'b1;
            end
          end else begin
            r_match_cnt <= '0;
          end
        end
        LOCKED: begin
          // Free-run the predictor so a corrupted word cannot derail tracking.
          r_pred <= w_next_pred;
          if (w_loss) begin
            r_state     <= HUNT;
            r_locked    <= 1'b0;
            r_match_cnt <= '0;
          end
        end
        default: begin
          r_state     <= HUNT;
          r_pred      <= 8'h01;
          r_match_cnt <= '0;
          r_locked    <= 1'b0;
        end
      endcase
    end
  end

  // Error pulse and saturating error counter; clear overrides an increment.
  always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
    if (SC_RegSHIFTER_RESET_InHigh) begin
      r_error  <= 1'b0;
      r_errcnt <= '0;
    end else begin
      r_error <= w_lock_mismatch;
      if (SC_LFSRCHK_clear_In) begin
        r_errcnt <= '0;
      end else if (w_lock_mismatch && !w_errcnt_full) begin
        r_errcnt <= r_errcnt + 1'b1;
      end
    end
  end

  assign SC_LFSRCHK_locked_Out      = r_locked;
  assign SC_LFSRCHK_error_Out       = r_error;
  assign SC_LFSRCHK_errcnt_OutBUS   = r_errcnt;
  assign SC_LFSRCHK_expected_OutBUS = r_pred;

endmodule

// File: tb/tb_sc_lfsr_checker.sv
// tb_sc_lfsr_checker
// Directed bench for sc_lfsr_checker. Each step drives one cycle of inputs,
// pushes the outputs expected after the next rising edge onto a scoreboard,
// then pops and compares them #1 after that edge.
module tb_sc_lfsr_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       clear = 1'b0;
  logic       locked;
  logic       error;
  logic [7:0] errcnt;
  logic [7:0] expected;

  int n_vec  = 0;
  int n_miss = 0;

  // Bench-side view of the checker while locked.
  logic [7:0] p          = 8'h01;
  int         exp_cnt    = 0;
  logic       exp_locked = 1'b0;

  typedef struct {
    string      tag;
    logic       locked;
    logic       err;
    logic [7:0] cnt;
    logic [7:0] expv;
    bit         chk_ex;
  } exp_t;

  exp_t sb[$];

  sc_lfsr_checker dut (
    .SC_RegSHIFTER_CLOCK_50     (clk),
    .SC_RegSHIFTER_RESET_InHigh (rst),
    .SC_LFSRCHK_data_InBUS      (data),
    .SC_LFSRCHK_valid_In        (valid),
    .SC_LFSRCHK_clear_In        (clear),
    .SC_LFSRCHK_locked_Out      (locked),
    .SC_LFSRCHK_error_Out       (error),
    .SC_LFSRCHK_errcnt_OutBUS   (errcnt),
    .SC_LFSRCHK_expected_OutBUS (expected)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[4]};
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".locked"}, {7'b0, locked}, {7'b0, e.locked});
      cmp({e.tag, ".error"},  {7'b0, error},  {7'b0, e.err});
      cmp({e.tag, ".errcnt"}, errcnt, e.cnt);
      if (e.chk_ex) cmp({e.tag, ".expected"}, expected, e.expv);
    end
  endtask

  // Drive one cycle, queue the expected post-edge outputs, check after the edge.
  task automatic step(input string tag, input logic v, input logic [7:0] d, input logic c,
                      input logic el, input logic ee, input logic [7:0] ec,
                      input logic [7:0] ex, input bit chk_ex);
    exp_t e;
    valid = v;
    data  = d;
    clear = c;
    e.tag = tag; e.locked = el; e.err = ee; e.cnt = ec; e.expv = ex; e.chk_ex = chk_ex;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
    valid = 1'b0;
    clear = 1'b0;
  endtask

  // One valid word while LOCKED: predictor free-runs, mismatches pulse and count.
  task automatic lw(input string tag, input logic [7:0] d, input logic c);
    logic       bad;
    logic [7:0] pn;
    bad = (d != p);
    if (c) exp_cnt = 0;
    else if (bad && exp_cnt < 255) exp_cnt++;
    pn = nxt(p);
    step(tag, 1'b1, d, c, exp_locked, bad, 8'(exp_cnt), pn, 1'b1);
    p = pn;
  endtask

  // Acquire from reset/HUNT with 01,02,04,08,10: lock on the fifth word.
  task automatic relock(input string tag);
    logic [7:0] w [5];
    logic [7:0] x [5];
    w = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    x = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h21};
    for (int i = 0; i < 5; i++)
      step($sformatf("%s_w%0d", tag, i), 1'b1, w[i], 1'b0, (i == 4), 1'b0,
           8'(exp_cnt), x[i], 1'b1);
    p = 8'h21;
    exp_locked = 1'b1;
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 0;
    exp_locked = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    cmp("rst.locked",   {7'b0, locked}, 8'h00);
    cmp("rst.error",    {7'b0, error},  8'h00);
    cmp("rst.errcnt",   errcnt,         8'h00);
    cmp("rst.expected", expected,       8'h01);
    rst = 1'b0;

    // Lockup value is ignored in HUNT.
    for (int i = 0; i < 10; i++)
      step("hunt_zero", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1);

    // Acquisition: locked rises on 0x10, predictor 0x21.
    relock("acq");

    // Single corrupted word while locked.
    lw("bad_ok21", 8'h21, 1'b0);
    lw("bad_43",   8'h43, 1'b0);
    lw("bad_ok84", 8'h84, 1'b0);
    lw("bad_ok09", 8'h09, 1'b0);

    // Valid-low gap: nothing moves.
    for (int i = 0; i < 2; i++)
      step("gap", 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'(exp_cnt), p, 1'b1);
    lw("after_gap", p, 1'b0);

    // Clear with valid low.
    exp_cnt = 0;
    step("clr_idle", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, p, 1'b1);

    // Three consecutive corrupted words.
    for (int k = 0; k < 3; k++) begin
`ifdef SC_LFSR_CHECKER_LOSSDET_EN
      if (k == 2) exp_locked = 1'b0;
`endif
      lw($sformatf("triple_bad%0d", k), p ^ 8'h5A, 1'b0);
    end
    cmp("triple.errcnt", errcnt, 8'h03);

    // Fresh lock, then saturate the error counter with 300 errors.
    sync_reset();
    relock("relock1");
    for (int i = 0; i < 450; i++)
      lw("sat", (i % 3 == 2) ? p : (p ^ 8'h80), 1'b0);
    cmp("sat.hold", errcnt, 8'hFF);

    // Clear coincident with a mismatch: clear wins, pulse still fires.
    lw("clr_mis", p ^ 8'h01, 1'b1);

    // Asynchronous reset between edges while locked.
    #2;
    rst = 1'b1;
    #1;
    cmp("arst.locked",   {7'b0, locked}, 8'h00);
    cmp("arst.error",    {7'b0, error},  8'h00);
    cmp("arst.errcnt",   errcnt,         8'h00);
    cmp("arst.expected", expected,       8'h01);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 0;
    exp_locked = 1'b0;
    relock("relock2");
    lw("relock2_track", p, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sc_lfsr_checker.md
SC_LFSR_CHECKER -- requirements
Module: sc_lfsr_checker

Interface
REQ-001 Parameter: LOCK_COUNT, 4, consecutive matches needed to declare lock.
REQ-002 Parameter: LOSS_COUNT, 3, consecutive mismatches that drop lock.
REQ-003 Parameter: ERRCNT_WIDTH, 8, width of the error counter.
REQ-004 Port: SC_RegSHIFTER_CLOCK_50  in  1  clock; every flop is rising-edge.
REQ-005 Port: SC_RegSHIFTER_RESET_InHigh  in  1  reset, asynchronous, active-high.
REQ-006 Port: SC_LFSRCHK_data_InBUS  in  8  received LFSR word, one per valid cycle.
REQ-007 Port: SC_LFSRCHK_valid_In  in  1  qualifies data_InBUS.
REQ-008 Port: SC_LFSRCHK_clear_In  in  1  synchronous clear of the error counter.
REQ-009 Port: SC_LFSRCHK_locked_Out  out  1  high while in LOCKED.
REQ-010 Port: SC_LFSRCHK_error_Out  out  1  one-cycle pulse per mismatched word.
REQ-011 Port: SC_LFSRCHK_errcnt_OutBUS  out  ERRCNT_WIDTH  saturating mismatch count.
REQ-012 Port: SC_LFSRCHK_expected_OutBUS  out  8  current predicted word.

Function
REQ-013 Successor function: next(x) = {x[6:0], x[7]^x[4]}, i.e. the 8-bit Fibonacci sequence 01,02,04,08,10,21,42,84,09...
REQ-014 States: HUNT, VERIFY, LOCKED; all outputs registered.
REQ-015 No state, predictor or counter change in any cycle with valid_In low, except clear_In.
REQ-016 HUNT: valid word 0x00 (lockup value) ignored; any other valid word -> predictor = next(data), match count = 0, go to VERIFY.
REQ-017 VERIFY: valid data == predictor -> match count +1, predictor = next(data); when the count reaches LOCK_COUNT -> LOCKED.
REQ-018 VERIFY: mismatch -> predictor = next(data), match count = 0, stay in VERIFY; no error pulse, no count.
REQ-019 LOCKED: predictor = next(predictor) on every valid word, regardless of match, so isolated bit errors do not derail tracking.
REQ-020 LOCKED mismatch -> error_Out high for exactly the following cycle; errcnt +1, saturating at all-ones.
REQ-021 LOCKED match -> consecutive-mismatch count cleared.
REQ-022 clear_In sets errcnt to 0 the next cycle; clear and increment in the same cycle -> 0 (clear wins); error_Out still pulses.
REQ-023 locked_Out is high starting with the edge that samples the LOCK_COUNT-th match.

Reset
REQ-024 Asserted reset, at any time including mid-lock: state HUNT, predictor 0x01, match and mismatch counts 0.
REQ-025 Reset values: locked_Out 0, error_Out 0, errcnt_OutBUS 0, expected_OutBUS 0x01.
REQ-026 First valid word is evaluated on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro SC_LFSR_CHECKER_LOSSDET_EN defined: LOSS_COUNT consecutive LOCKED mismatches -> HUNT; locked_Out low at that edge; counts zeroed.
REQ-028 Macro not defined: LOCKED is left only by reset; mismatch-count logic is absent; errors are still counted.

Verification
REQ-029 Valid each cycle 01,02,04,08,10 -> locked_Out rises at the edge that samples 0x10; expected_OutBUS = 0x21; errcnt 0.
REQ-030 Locked; send 21,43(bad),84,09 -> one error_Out pulse after 0x43; errcnt = 1; locked stays high; 0x84 and 0x09 match.
REQ-031 Locked; three consecutive corrupted words -> with LOSSDET_EN: locked_Out low, state HUNT, errcnt = 3; without: locked stays high, errcnt = 3.
REQ-032 Valid 0x00 repeated 10 cycles after reset -> stays HUNT, locked_Out 0, no error pulses; valid low gaps mid-sequence -> lock unaffected.
REQ-033 Force 300 locked errors -> errcnt holds 0xFF; clear_In together with a mismatch -> errcnt 0x00, error_Out pulses.
REQ-034 Reset asserted mid-lock between clock edges -> all outputs reach reset values immediately, without a clock edge; relock needs 1 + LOCK_COUNT valid words.
